// File: rtl/mod503_pkg.sv
// Shared definitions for the mod-503 residue datapath.
// Holds the modulus, the residue width, the default frame length, the residue
// type and the accumulator FSM state encoding.
package mod503_pkg;

    localparam int unsigned MODULUS    = 503;
    localparam int unsigned RES_W      = 9;
    localparam int unsigned NUM_CHUNKS = 84;  // ceil(500 / 6) LUT slices per operand

    typedef logic [RES_W-1:0] residue_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/mod503_add.sv
// Combinational modular adder: sum_o = (a_i + b_i) mod MODULUS.
// Both operands are expected in [0, MODULUS-1], so one conditional subtract
// is enough.
//
// Optional feature (macro MOD503_RANGE_CHECK_EN):
//   defined   - b_i >= MODULUS is pre-reduced by one MODULUS before the add
//               and flagged on range_err_o.
//   undefined - b_i is trusted; range_err_o is tied low.
//
// Ports:
//   a_i         residue operand (must already be reduced)
//   b_i         residue operand (incoming LUT residue)
//   sum_o       (a_i + b_i) mod MODULUS
//   range_err_o b_i was out of range (only with MOD503_RANGE_CHECK_EN)
module mod503_add
    import mod503_pkg::*;
(
    input  residue_t a_i,
    input  residue_t b_i,
    output residue_t sum_o,
    output logic     range_err_o
);

    localparam logic [RES_W:0] ModW = (RES_W + 1)'(MODULUS);

    residue_t       b_red;
    logic [RES_W:0] s;

`ifdef MOD503_RANGE_CHECK_EN
    // A 9-bit value is below 2*MODULUS, so one subtract brings it into range.
    always_comb begin
        range_err_o = ({1'b0, b_i} >= ModW);
        b_red       = range_err_o ? RES_W'({1'b0, b_i} - ModW) : b_i;
    end
`else
    assign range_err_o = 1'b0;
    assign b_red       = b_i;
`endif

    // One extra bit holds the raw sum, which is at most 2*(MODULUS-1).
    assign s     = {1'b0, a_i} + {1'b0, b_red};
    assign sum_o = (s >= ModW) ? RES_W'(s - ModW) : s[RES_W-1:0];

endmodule

// File: rtl/mod503_residue_accumulator.sv
// Accumulates a frame of per-chunk LUT residues modulo MODULUS and emits the
// residue of the whole operand over a valid/ready handshake.
//
// A frame ends on the first accepted beat that carries in_last_i or brings
// the beat count to NUM_CHUNKS. If those two disagree, out_err_o is set.
// With MOD503_RANGE_CHECK_EN defined, out-of-range residues are pre-reduced
// and also raise out_err_o for the frame.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   residue beat valid
//   in_ready_o   beat can be accepted (low while a result is pending)
//   in_res_i     residue of the current chunk
//   in_last_i    final chunk of the frame
//   out_valid_o  frame result valid
//   out_ready_i  consumer accepts the result
//   out_res_o    operand mod MODULUS (holds its value after the handshake)
//   out_err_o    frame-length mismatch or range fault, qualified by out_valid_o
module mod503_residue_accumulator #(
    parameter int unsigned NUM_CHUNKS = mod503_pkg::NUM_CHUNKS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  mod503_pkg::residue_t in_res_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output mod503_pkg::residue_t out_res_o,
    output logic                 out_err_o
);

    import mod503_pkg::*;

    localparam int unsigned      CNT_W   = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_CHUNKS);

    state_t           state_q, state_d;
    residue_t         acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             out_valid_q, out_valid_d;
    residue_t         out_res_q, out_res_d;
    logic             out_err_q, out_err_d;
    logic             fault_q, fault_d;  // sticky range fault for the current frame

    residue_t sum;
    logic     range_err;
    logic     accept;
    logic     hit_max;
    logic     frame_end;

    // acc_q is always zero in IDLE, so the first beat passes through the
    // adder unchanged and no separate load path is needed.
    mod503_add u_add (
        .a_i         (acc_q),
        .b_i         (in_res_i),
        .sum_o       (sum),
        .range_err_o (range_err)
    );

    assign in_ready_o  = (state_q != DONE);
    assign out_valid_o = out_valid_q;
    assign out_res_o   = out_res_q;
    assign out_err_o   = out_err_q;

    assign accept    = in_valid_i & in_ready_o;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign hit_max   = (cnt_inc == LastCnt);
    assign frame_end = in_last_i | hit_max;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_err_d   = out_err_q;
        fault_d     = fault_q;

        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = sum;
                    cnt_d   = cnt_inc;
                    fault_d = fault_q | range_err;
                    if (frame_end) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_res_d   = sum;
                        out_err_d   = (in_last_i ^ hit_max) | fault_q | range_err;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    fault_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_err_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_err_q   <= out_err_d;
            fault_q     <= fault_d;
        end
    end

endmodule

// File: tb/tb_mod503_residue_accumulator.sv
module tb_mod503_residue_accumulator;

    typedef struct packed {
        logic [8:0] res;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    // Instance with NUM_CHUNKS = 4 (sel = 0) and default 84 (sel = 1).
    logic       in_valid4, in_ready4, in_last4, out_valid4, out_ready4, out_err4;
    logic [8:0] in_res4, out_res4;
    logic       in_valid84, in_ready84, in_last84, out_valid84, out_ready84, out_err84;
    logic [8:0] in_res84, out_res84;

    exp_t q4[$];
    exp_t q84[$];
    int   checks = 0;
    int   errors = 0;
    int   model_sum;

    always #5 clk = ~clk;

    mod503_residue_accumulator #(.NUM_CHUNKS(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid4),
        .in_ready_o  (in_ready4),
        .in_res_i    (in_res4),
        .in_last_i   (in_last4),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready4),
        .out_res_o   (out_res4),
        .out_err_o   (out_err4)
    );

    mod503_residue_accumulator dut84 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid84),
        .in_ready_o  (in_ready84),
        .in_res_i    (in_res84),
        .in_last_i   (in_last84),
        .out_valid_o (out_valid84),
        .out_ready_i (out_ready84),
        .out_res_o   (out_res84),
        .out_err_o   (out_err84)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [8:0] r, input logic l);
        if (sel) begin
            in_valid84 = v; in_res84 = r; in_last84 = l;
        end else begin
            in_valid4 = v; in_res4 = r; in_last4 = l;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic beat(input bit sel, input logic [8:0] r, input logic l);
        int n = 0;
        drive(sel, 1'b1, r, l);
        while (!(sel ? in_ready84 : in_ready4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        drive(sel, 1'b0, 9'd0, 1'b0);
    endtask

    // Waits for a result, compares it against the scoreboard, optionally
    // stalls the consumer for 'hold' cycles with junk beats offered, then
    // completes the handshake.
    task automatic collect(input bit sel, input int hold);
        int   n = 0;
        exp_t e;
        while (!(sel ? out_valid84 : out_valid4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", {31'd0, sel ? out_valid84 : out_valid4}, 32'd1);
        if ((sel ? q84.size() : q4.size()) == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sel ? q84.pop_front() : q4.pop_front();
        check("out_res", {23'd0, sel ? out_res84 : out_res4}, {23'd0, e.res});
        check("out_err", {31'd0, sel ? out_err84 : out_err4}, {31'd0, e.err});
        for (int i = 0; i < hold; i++) begin
            drive(sel, 1'b1, 9'd7, 1'b1);
            @(negedge clk);
            check("hold_in_ready", {31'd0, sel ? in_ready84 : in_ready4}, 32'd0);
            check("hold_out_valid", {31'd0, sel ? out_valid84 : out_valid4}, 32'd1);
            check("hold_out_res", {23'd0, sel ? out_res84 : out_res4}, {23'd0, e.res});
            check("hold_out_err", {31'd0, sel ? out_err84 : out_err4}, {31'd0, e.err});
        end
        if (sel) out_ready84 = 1'b1; else out_ready4 = 1'b1;
        @(negedge clk);
        drive(sel, 1'b0, 9'd0, 1'b0);
        if (sel) out_ready84 = 1'b0; else out_ready4 = 1'b0;
        check("post_hs_out_valid", {31'd0, sel ? out_valid84 : out_valid4}, 32'd0);
        check("post_hs_in_ready", {31'd0, sel ? in_ready84 : in_ready4}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 9'd0, 1'b0);
        drive(1'b1, 1'b0, 9'd0, 1'b0);
        out_ready4  = 1'b0;
        out_ready84 = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready4}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        check("rst_out_res", {23'd0, out_res4}, 32'd0);
        check("rst_out_err", {31'd0, out_err4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 502 x4: 1004-503=501, 1003-503=500, 1002-503=499
        beat(1'b0, 9'd502, 1'b0);
        beat(1'b0, 9'd502, 1'b0);
        beat(1'b0, 9'd502, 1'b0);
        check("no_early_valid", {31'd0, out_valid4}, 32'd0);
        q4.push_back('{res: 9'd499, err: 1'b0});
        beat(1'b0, 9'd502, 1'b1);
        check("latency_one_cycle", {31'd0, out_valid4}, 32'd1);
        collect(1'b0, 0);

        // 1 + 502 wraps exactly to 0; stall the consumer 5 cycles
        beat(1'b0, 9'd1, 1'b0);
        beat(1'b0, 9'd502, 1'b0);
        beat(1'b0, 9'd0, 1'b0);
        q4.push_back('{res: 9'd0, err: 1'b0});
        beat(1'b0, 9'd0, 1'b1);
        collect(1'b0, 5);

        // all-zero frame, started right after the stalled handshake
        for (int i = 0; i < 4; i++) beat(1'b0, 9'd0, i == 3);
        q4.push_back('{res: 9'd0, err: 1'b0});
        collect(1'b0, 0);

        // early in_last on beat 2
        beat(1'b0, 9'd10, 1'b0);
        q4.push_back('{res: 9'd30, err: 1'b1});
        beat(1'b0, 9'd20, 1'b1);
        collect(1'b0, 0);

        // missing in_last at NUM_CHUNKS
        for (int i = 1; i <= 4; i++) beat(1'b0, 9'(i), 1'b0);
        q4.push_back('{res: 9'd10, err: 1'b1});
        collect(1'b0, 0);

        // 84-beat frame with random gaps and a 10-cycle stall mid-frame
        model_sum = 0;
        for (int i = 0; i < 84; i++) begin
            int r;
            r = int'($urandom_range(0, 502));
            beat(1'b1, 9'(r), i == 83);
            model_sum = (model_sum + r) % 503;
            if (i == 40) begin
                check("acc_before_gap", {23'd0, dut84.acc_q}, 32'(model_sum));
                repeat (10) @(negedge clk);
                check("acc_after_gap", {23'd0, dut84.acc_q}, 32'(model_sum));
                check("gap_no_valid", {31'd0, out_valid84}, 32'd0);
            end else if (i < 83) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        q84.push_back('{res: 9'(model_sum), err: 1'b0});
        collect(1'b1, 0);

        // reset mid-frame discards the partial sum
        beat(1'b0, 9'd100, 1'b0);
        beat(1'b0, 9'd200, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready4}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid4}, 32'd0);
        check("midrst_out_res", {23'd0, out_res4}, 32'd0);
        check("midrst_out_err", {31'd0, out_err4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_output", {31'd0, out_valid4}, 32'd0);
        for (int i = 5; i <= 8; i++) beat(1'b0, 9'(i), i == 8);
        q4.push_back('{res: 9'd26, err: 1'b0});
        collect(1'b0, 0);

`ifdef MOD503_RANGE_CHECK_EN
        // 510 pre-reduces to 7: 7+1+1+1 = 10, range fault reported
        beat(1'b0, 9'd510, 1'b0);
        beat(1'b0, 9'd1, 1'b0);
        beat(1'b0, 9'd1, 1'b0);
        q4.push_back('{res: 9'd10, err: 1'b1});
        beat(1'b0, 9'd1, 1'b1);
        collect(1'b0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
